// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit: fetches from instruction memory and issues op/func codes to the control unit
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   imem_req/imem_addr  fetch request (high only in FETCH) and address (always pc)
//   imem_ack/imem_rdata/imem_err  memory response; rdata and err qualified by ack
//   inst_valid, op_code, func_code  current instruction presented to the control unit
//   advance, halt, redirect, target  control unit consumes the instruction, halts, or jumps
//   pc                  address of the current/next fetch
//   exc_inst_memory     sticky fetch exception (bus error, timeout, misaligned target)
//   halted              fetch stopped until reset
module inst_fetch #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    INST_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000,
  parameter int                    TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  imem_err,
  output logic                  inst_valid,
  output logic [3:0]            op_code,
  output logic [3:0]            func_code,
  input  logic                  advance,
  input  logic                  halt,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  exc_inst_memory,
  output logic                  halted
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic [INST_WIDTH-1:0] ir, ir_nxt;
  logic [CNT_W-1:0]      tmo_cnt, tmo_cnt_nxt;
  logic                  exc_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      ir              <= '0;
      tmo_cnt         <= '0;
      exc_inst_memory <= 1'b0;
    end else begin
      state           <= state_nxt;
      pc              <= pc_nxt;
      ir              <= ir_nxt;
      tmo_cnt         <= tmo_cnt_nxt;
      exc_inst_memory <= exc_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_nxt      = ir;
    tmo_cnt_nxt = tmo_cnt;
    exc_nxt     = exc_inst_memory;
    case (state)
      IDLE: begin
        state_nxt   = FETCH;
        tmo_cnt_nxt = '0;
      end
      FETCH: begin
        // An ack in the last allowed cycle still wins over the timeout.
        if (imem_ack) begin
          if (imem_err) begin
            exc_nxt   = 1'b1;
            state_nxt = HALTED;
          end else begin
            ir_nxt    = imem_rdata;
            state_nxt = ISSUE;
          end
        end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
          exc_nxt   = 1'b1;
          state_nxt = HALTED;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 1'b1;
        end
      end
      ISSUE: begin
        if (advance) begin
          tmo_cnt_nxt = '0;
          if (halt) begin
            state_nxt = HALTED;
          end else if (redirect) begin
            // Instructions are 2-byte aligned; an odd target cannot be fetched.
            if (target[0]) begin
              exc_nxt   = 1'b1;
              state_nxt = HALTED;
            end else begin
              pc_nxt    = target;
              state_nxt = FETCH;
            end
          end else begin
            pc_nxt    = pc + ADDR_WIDTH'(2);
            state_nxt = FETCH;
          end
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign imem_req   = (state == FETCH);
  assign imem_addr  = pc;
  assign inst_valid = (state == ISSUE);
  assign halted     = (state == HALTED);
  assign op_code    = ir[15:12];
  assign func_code  = ir[3:0];

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch with an instruction scoreboard
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        imem_err;
  logic        inst_valid;
  logic [3:0]  op_code;
  logic [3:0]  func_code;
  logic        advance;
  logic        halt;
  logic        redirect;
  logic [15:0] target;
  logic [15:0] pc;
  logic        exc_inst_memory;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [7:0] sb[$];

  inst_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .imem_err        (imem_err),
    .inst_valid      (inst_valid),
    .op_code         (op_code),
    .func_code       (func_code),
    .advance         (advance),
    .halt            (halt),
    .redirect        (redirect),
    .target          (target),
    .pc              (pc),
    .exc_inst_memory (exc_inst_memory),
    .halted          (halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b0; imem_ack = 1'b0; imem_err = 1'b0;
    advance = 1'b0; halt = 1'b0; redirect = 1'b0; target = '0;
    sb.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Waits (bounded) for a fetch request, answers it in that cycle, records the expected issue.
  task automatic fetch_ack(input logic [15:0] data, input logic err, output int waits);
    waits = 0;
    while (!imem_req && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    n_cmp++;
    if (imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_wait: imem_req=%b after %0d cycles, required 1", imem_req, waits);
    end else begin
      imem_ack = 1'b1; imem_rdata = data; imem_err = err;
      if (!err) sb.push_back({data[15:12], data[3:0]});
    end
    @(negedge clk);
    imem_ack = 1'b0; imem_err = 1'b0; imem_rdata = 16'($urandom);
  endtask

  // Compares the presented instruction against the scoreboard, then drives one control cycle.
  task automatic issue_take(input logic adv, input logic hlt, input logic rdr, input logic [15:0] tgt);
    logic [7:0] exp;
    n_cmp++;
    if (inst_valid !== 1'b1) begin
      n_err++;
      $display("FAIL issue_valid: inst_valid=%b, required 1", inst_valid);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL issue_sb: op/func=%h with empty scoreboard", {op_code, func_code});
    end else begin
      exp = sb.pop_front();
      if ({op_code, func_code} !== exp) begin
        n_err++;
        $display("FAIL issue_data: op/func=%h, required %h", {op_code, func_code}, exp);
      end
    end
    advance = adv; halt = hlt; redirect = rdr; target = tgt;
    @(negedge clk);
    advance = 1'b0; halt = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_ack = 1'b1; imem_err = 1'b0; imem_rdata = 16'hFFFF;
    advance = 1'b1; halt = 1'b0; redirect = 1'b0; target = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({imem_req, inst_valid, halted, exc_inst_memory, op_code, func_code, pc, imem_addr} !== 44'h0) begin
      n_err++;
      $display("FAIL reset_state: req=%b valid=%b halted=%b exc=%b op=%h func=%h pc=%h addr=%h, required all 0",
               imem_req, inst_valid, halted, exc_inst_memory, op_code, func_code, pc, imem_addr);
    end
    imem_ack = 1'b0; advance = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: req=%b addr=%h valid=%b, required 1 0000 0", imem_req, imem_addr, inst_valid);
    end
  endtask

  task automatic test_basic();
    int w;
    fetch_ack(16'h0F0F, 1'b0, w);
    n_cmp++;
    if (w != 0) begin
      n_err++;
      $display("FAIL basic_first_fetch: waited %0d cycles, required 0", w);
    end
    issue_take(1'b1, 1'b0, 1'b0, 16'h0);
    n_cmp++;
    if (pc !== 16'h0002 || imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL basic_next_pc: pc=%h req=%b, required 0002 1", pc, imem_req);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int c0;
    int bad = 0;
    logic [15:0] exp_pc = 16'h0002;
    c0 = cyc;
    for (int i = 0; i < 7; i++) begin
      fetch_ack(16'($urandom), 1'b0, w);
      issue_take(1'b1, 1'b0, 1'b0, 16'h0);
      exp_pc = exp_pc + 16'd2;
      if (w != 0 || pc !== exp_pc || imem_req !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0 || pc !== 16'h0010) begin
      n_err++;
      $display("FAIL b2b_seq: %0d bad steps, pc=%h, required 0 bad and pc 0010", bad, pc);
    end
    n_cmp++;
    if (cyc - c0 != 14) begin
      n_err++;
      $display("FAIL b2b_throughput: %0d cycles for 7 instructions, required 14", cyc - c0);
    end
  endtask

  task automatic test_redirect();
    int w;
    fetch_ack(16'hA5C3, 1'b0, w);
    issue_take(1'b1, 1'b0, 1'b1, 16'h0040);
    n_cmp++;
    if (imem_addr !== 16'h0040 || imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL redirect_target: addr=%h req=%b, required 0040 1", imem_addr, imem_req);
    end
    fetch_ack(16'h3C5A, 1'b0, w);
    issue_take(1'b1, 1'b0, 1'b1, 16'h0041);
    n_cmp++;
    if (exc_inst_memory !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0 || pc !== 16'h0040) begin
      n_err++;
      $display("FAIL redirect_odd: exc=%b halted=%b req=%b pc=%h, required 1 1 0 0040",
               exc_inst_memory, halted, imem_req, pc);
    end
  endtask

  task automatic test_mem_error();
    int w;
    do_reset();
    fetch_ack(16'h1234, 1'b1, w);
    n_cmp++;
    if (exc_inst_memory !== 1'b1 || halted !== 1'b1 || inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mem_error: exc=%b halted=%b valid=%b, required 1 1 0", exc_inst_memory, halted, inst_valid);
    end
  endtask

  task automatic test_timeout();
    int w;
    do_reset();
    repeat (7) @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || halted !== 1'b0 || exc_inst_memory !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_early: req=%b halted=%b exc=%b after 7 cycles, required 1 0 0",
               imem_req, halted, exc_inst_memory);
    end
    @(negedge clk);
    n_cmp++;
    if (halted !== 1'b1 || exc_inst_memory !== 1'b1 || imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_expire: halted=%b exc=%b req=%b after 8 cycles, required 1 1 0",
               halted, exc_inst_memory, imem_req);
    end
    do_reset();
    repeat (7) @(negedge clk);
    fetch_ack(16'h7E81, 1'b0, w);
    n_cmp++;
    if (inst_valid !== 1'b1 || exc_inst_memory !== 1'b0 || halted !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_ack_last: valid=%b exc=%b halted=%b, required 1 0 0",
               inst_valid, exc_inst_memory, halted);
    end
    issue_take(1'b1, 1'b0, 1'b0, 16'h0);
    // The counter must start over for the next fetch.
    repeat (7) @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || halted !== 1'b0 || pc !== 16'h0002) begin
      n_err++;
      $display("FAIL timeout_clear: req=%b halted=%b pc=%h, required 1 0 0002", imem_req, halted, pc);
    end
  endtask

  task automatic test_halt();
    int w;
    int bad = 0;
    do_reset();
    fetch_ack(16'hF00D, 1'b0, w);
    issue_take(1'b1, 1'b1, 1'b1, 16'h0040);
    n_cmp++;
    if (halted !== 1'b1 || pc !== 16'h0000 || exc_inst_memory !== 1'b0) begin
      n_err++;
      $display("FAIL halt_enter: halted=%b pc=%h exc=%b, required 1 0000 0", halted, pc, exc_inst_memory);
    end
    for (int i = 0; i < 20; i++) begin
      advance = 1'b1; redirect = 1'b1; target = 16'h0080; imem_ack = 1'($urandom);
      @(negedge clk);
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b1 || pc !== 16'h0000) bad++;
    end
    advance = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL halt_terminal: %0d of 20 cycles left HALTED, required 0", bad);
    end
  endtask

  task automatic test_wrap_stall();
    int w;
    int bad = 0;
    logic [7:0] held;
    do_reset();
    fetch_ack(16'h0001, 1'b0, w);
    issue_take(1'b1, 1'b0, 1'b1, 16'hFFFE);
    advance = 1'b1; redirect = 1'b1; target = 16'h0020;
    repeat (2) @(negedge clk);
    advance = 1'b0; redirect = 1'b0;
    n_cmp++;
    if (imem_addr !== 16'hFFFE || imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_ignores_ctrl: addr=%h req=%b, required FFFE 1", imem_addr, imem_req);
    end
    fetch_ack(16'hB2C4, 1'b0, w);
    held = {op_code, func_code};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({op_code, func_code} !== held || pc !== 16'hFFFE || inst_valid !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL stall_stable: %0d of 5 stall cycles changed, required 0", bad);
    end
    issue_take(1'b1, 1'b0, 1'b0, 16'h0);
    n_cmp++;
    if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL pc_wrap: addr=%h req=%b, required 0000 1", imem_addr, imem_req);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    fetch_ack(16'h9999, 1'b0, w);
    issue_take(1'b1, 1'b0, 1'b1, 16'h0080);
    #2;
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0 || pc !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_async_fetch: req=%b pc=%h, required 0 0000", imem_req, pc);
    end
    repeat (2) @(negedge clk);
    imem_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_restart: req=%b addr=%h valid=%b, required 1 0000 0", imem_req, imem_addr, inst_valid);
    end
    fetch_ack(16'h5AF0, 1'b0, w);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (inst_valid !== 1'b0 || op_code !== 4'h0 || func_code !== 4'h0) begin
      n_err++;
      $display("FAIL reset_async_issue: valid=%b op=%h func=%h, required 0 0 0", inst_valid, op_code, func_code);
    end
    void'(sb.pop_front());
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    imem_rdata = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_redirect();
    test_mem_error();
    test_timeout();
    test_halt();
    test_wrap_stall();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d instructions never issued, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
